conv_pe_sequencer: RTL and testbench

//  Main convolution sequencer of the CNN processing element. Drives the IFmap and filter

---
 rtl/conv_pe_pkg.sv | 51 +++++
 rtl/conv_pe_sequencer_if.sv | 57 +++++
 rtl/conv_pe_sequencer.sv | 140 ++++++++++++++
 tb/tb_conv_pe_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pe_pkg
// Purpose  : Shared definitions for the CNN processing-element convolution
//            sequencer: state encodings, the state enum, the strobe bundle
//            and the default address/count width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package conv_pe_pkg;

  // Default width of address/count fields and of the psum output address.
  localparam int CONFIG_BIT_DEF = 4;

  // State encodings.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_ACC   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;
  localparam logic [2:0] S_ROWSW = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_LOAD  = S_LOAD,
    ST_FETCH = S_FETCH,
    ST_ACC   = S_ACC,
    ST_DONE  = S_DONE,
    ST_NEXT  = S_NEXT,
    ST_ROWSW = S_ROWSW
  } state_e;

  // Per-cycle control strobes decoded from the sequencer state.
  typedef struct packed {
    logic ldds;
    logic dsen;
    logic sel_next;
    logic ferst;
    logic feen;
    logic wfrst;
    logic wfen;
    logic chipen;
    logic filterren;
    logic acc_clr;
    logic acc_en;
    logic done;
  } strobe_t;

endpackage
`default_nettype wire

// File: rtl/conv_pe_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_pe_sequencer_if
// Purpose  : Bundles the status inputs and control/handshake outputs of the
//            convolution sequencer.
// Ports    : master modport - sequencer side (status in, strobes out)
//            slave  modport - datapath / controller side (mirror image)
//            Status : row_ready, stall, wr_busy, elco, wfco, end_of_row
//            Control: ldds, dsen, sel_next, num, ferst, feen, wfrst, wfen,
//                     chipen, filterren, acc_clr, acc_en, done, out_addr, busy
// Revision : 1.0 - initial release
// ============================================================================
interface conv_pe_sequencer_if
  import conv_pe_pkg::*;
#(
  parameter int CONFIG_BIT = CONFIG_BIT_DEF
);

  // Status from the surrounding datapath / controllers
  logic                  row_ready;
  logic                  stall;
  logic                  wr_busy;
  logic                  elco;
  logic                  wfco;
  logic                  end_of_row;

  // Control toward address generators, filter SRAM, accumulator, writer
  logic                  ldds;
  logic                  dsen;
  logic                  sel_next;
  logic                  num;
  logic                  ferst;
  logic                  feen;
  logic                  wfrst;
  logic                  wfen;
  logic                  chipen;
  logic                  filterren;
  logic                  acc_clr;
  logic                  acc_en;
  logic                  done;
  logic [CONFIG_BIT-1:0] out_addr;
  logic                  busy;

  modport master (
    input  row_ready, stall, wr_busy, elco, wfco, end_of_row,
    output ldds, dsen, sel_next, num, ferst, feen, wfrst, wfen,
           chipen, filterren, acc_clr, acc_en, done, out_addr, busy
  );

  modport slave (
    output row_ready, stall, wr_busy, elco, wfco, end_of_row,
    input  ldds, dsen, sel_next, num, ferst, feen, wfrst, wfen,
           chipen, filterren, acc_clr, acc_en, done, out_addr, busy
  );

endinterface
`default_nettype wire

// File: rtl/conv_pe_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv_pe_sequencer
// Purpose  : Main convolution sequencer of the CNN processing element.
//            Walks each (window, filter) pair: loads the window start,
//            fetches filter elements, accumulates, hands the psum to the
//            write controller with a one-cycle done pulse, then advances to
//            the next filter, the next window, or the next IFmap row slot.
// Ports    : clk  - single clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - conv_pe_sequencer_if.master (status in, strobes out,
//                   registered num / out_addr, busy)
// Revision : 1.0 - initial release
// ============================================================================
module conv_pe_sequencer
  import conv_pe_pkg::*;
#(
  parameter int CONFIG_BIT = CONFIG_BIT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  conv_pe_sequencer_if.master bus
);

  state_e                state_q, state_d;
  logic                  num_q, num_d;
  logic [CONFIG_BIT-1:0] out_addr_q, out_addr_d;
  strobe_t               strb;

  // Next-state and strobe decode. Strobes come from the current state; only
  // FETCH (stall), DONE (wr_busy) and NEXT (wfco / end_of_row) qualify them
  // with an input, so a hold cycle never emits a partial action.
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    out_addr_d = out_addr_q;
    strb       = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.row_ready) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        strb.ldds    = 1'b1;
        strb.ferst   = 1'b1;
        strb.wfrst   = 1'b1;
        strb.acc_clr = 1'b1;
        state_d      = ST_FETCH;
      end

      ST_FETCH: begin
        if (!bus.stall) begin
          strb.chipen    = 1'b1;
          strb.filterren = 1'b1;
          state_d        = ST_ACC;   // SRAM data arrives next cycle
        end
      end

      ST_ACC: begin
        strb.acc_en = 1'b1;
        strb.feen   = 1'b1;
        state_d     = bus.elco ? ST_DONE : ST_FETCH;
      end

      ST_DONE: begin
        if (!bus.wr_busy) begin
          strb.done  = 1'b1;
          out_addr_d = out_addr_q + 1'b1;   // wraps naturally
          state_d    = ST_NEXT;
        end
      end

      ST_NEXT: begin
        strb.ferst   = 1'b1;
        strb.acc_clr = 1'b1;
        if (!bus.wfco) begin
          // Same window, next filter
          strb.wfen = 1'b1;
          state_d   = ST_FETCH;
        end else if (!bus.end_of_row) begin
          // All filters done: slide window by stride
          strb.wfrst = 1'b1;
          strb.dsen  = 1'b1;
          state_d    = ST_FETCH;
        end else begin
          // Row complete: switch to the other IFmap row slot
          strb.wfrst = 1'b1;
          num_d      = ~num_q;
          state_d    = ST_ROWSW;
        end
      end

      ST_ROWSW: begin
        // Preload the end registers of the newly active slot
        strb.ldds     = 1'b1;
        strb.sel_next = 1'b1;
        state_d       = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A cycle with reset asserted never issues an action, so an aborted
    // psum cannot leak a done pulse.
    if (rst) strb = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      num_q      <= 1'b0;
      out_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      out_addr_q <= out_addr_d;
    end
  end

  assign bus.ldds      = strb.ldds;
  assign bus.dsen      = strb.dsen;
  assign bus.sel_next  = strb.sel_next;
  assign bus.ferst     = strb.ferst;
  assign bus.feen      = strb.feen;
  assign bus.wfrst     = strb.wfrst;
  assign bus.wfen      = strb.wfen;
  assign bus.chipen    = strb.chipen;
  assign bus.filterren = strb.filterren;
  assign bus.acc_clr   = strb.acc_clr;
  assign bus.acc_en    = strb.acc_en;
  assign bus.done      = strb.done;
  assign bus.num       = num_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.busy      = (state_q != ST_IDLE) && !rst;

endmodule
`default_nettype wire

// File: tb/tb_conv_pe_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_pe_sequencer
// Purpose  : Directed self-checking bench for conv_pe_sequencer. A tiny
//            datapath model (filter_element / which_filter counters) produces
//            elco / wfco from the sequencer strobes; stall, wr_busy, row_ready
//            and reset follow per-test cycle windows. Expected values are
//            hand-computed cycle numbers and counts.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_pe_sequencer;
  import conv_pe_pkg::*;

  localparam int CB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_pe_sequencer_if #(.CONFIG_BIT(CB)) bus ();

  conv_pe_sequencer #(.CONFIG_BIT(CB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Test configuration
  int   cyc = 0;
  int   fs = 3, nf = 1;
  logic eor = 1'b0;
  int   rr0 = -10, rr1 = -10;
  int   st_lo = -10, st_hi = -10;
  int   wb_lo = -10, wb_hi = -10;
  int   rst_at = -10;
  logic rst_hold = 1'b1;

  // Datapath model state
  int   fe = 0, wf = 0;
  logic p_ferst = 1'b0, p_feen = 1'b0, p_wfrst = 1'b0, p_wfen = 1'b0;

  // Monitors
  int n_done, done_cyc, n_chipen, n_feen, n_wfen, n_dsen, n_rowsw, n_stall_act;
  int n_overlap = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, sample on the
  // falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (p_ferst)     fe = 0;
    else if (p_feen) fe++;
    if (p_wfrst)     wf = 0;
    else if (p_wfen) wf++;
    rst            = rst_hold || (cyc == rst_at);
    bus.row_ready  = (cyc == rr0) || (cyc == rr1);
    bus.elco       = (fe == fs - 1);
    bus.wfco       = (wf == nf - 1);
    bus.end_of_row = eor;
    bus.stall      = (cyc >= st_lo) && (cyc < st_hi);
    bus.wr_busy    = (cyc >= wb_lo) && (cyc < wb_hi);
    @(negedge clk);
    p_ferst = bus.ferst;
    p_feen  = bus.feen;
    p_wfrst = bus.wfrst;
    p_wfen  = bus.wfen;
    if (bus.done) begin n_done++; done_cyc = cyc; end
    if (bus.chipen) n_chipen++;
    if (bus.feen)   n_feen++;
    if (bus.wfen)   n_wfen++;
    if (bus.dsen)   n_dsen++;
    if (bus.ldds && bus.sel_next) n_rowsw++;
    if (bus.stall && (bus.chipen || bus.feen)) n_stall_act++;
    if ((bus.feen && bus.ferst) || (bus.wfen && bus.wfrst)) n_overlap++;
  endtask

  task automatic run_to(input int c);
    for (int k = 0; k < 200 && cyc < c; k++) step();
  endtask

  // Reset the DUT, check reset values, then arm a new test with cycle 0 as
  // the IDLE cycle in which row_ready is first seen.
  task automatic begin_test(input string name, input int f, input int n, input logic e);
    rr0 = -10; rr1 = -10; st_lo = -10; st_hi = -10;
    wb_lo = -10; wb_hi = -10; rst_at = -10;
    rst_hold = 1'b1;
    step();
    step();
    chk({name, "_rst_busy"},     bus.busy,     0);
    chk({name, "_rst_num"},      bus.num,      0);
    chk({name, "_rst_out_addr"}, bus.out_addr, 0);
    chk({name, "_rst_done"},     bus.done,     0);
    n_done = 0; done_cyc = -1; n_chipen = 0; n_feen = 0;
    n_wfen = 0; n_dsen = 0; n_rowsw = 0; n_stall_act = 0;
    fs = f; nf = n; eor = e;
    rr0 = 0;
    rst_hold = 1'b0;
    cyc = -1;
  endtask

  initial begin
    bus.row_ready = 1'b0; bus.stall = 1'b0; bus.wr_busy = 1'b0;
    bus.elco = 1'b0; bus.wfco = 1'b0; bus.end_of_row = 1'b0;

    // 1: basic psum, 3 elements, single filter, window slides
    begin_test("t1", 3, 1, 1'b0);
    run_to(1);
    chk("t1_load_ldds", bus.ldds, 1);
    run_to(9);
    chk("t1_done_cyc",  done_cyc, 8);
    chk("t1_n_done",    n_done,   1);
    chk("t1_n_chipen",  n_chipen, 3);
    chk("t1_out_addr",  bus.out_addr, 1);
    chk("t1_dsen",      bus.dsen, 1);
    chk("t1_wfrst",     bus.wfrst, 1);

    // 2: 4-cycle stall entering the second FETCH (cycles 4..7)
    begin_test("t2", 3, 1, 1'b0);
    st_lo = 4; st_hi = 8;
    run_to(12);
    chk("t2_done_cyc",   done_cyc,    12);
    chk("t2_stall_act",  n_stall_act, 0);
    chk("t2_n_chipen",   n_chipen,    3);
    chk("t2_n_feen",     n_feen,      3);

    // 3: wr_busy for 5 cycles at DONE (cycles 8..12)
    begin_test("t3", 3, 1, 1'b0);
    wb_lo = 8; wb_hi = 13;
    run_to(12);
    chk("t3_held_done",     n_done,       0);
    chk("t3_held_out_addr", bus.out_addr, 0);
    chk("t3_held_busy",     bus.busy,     1);
    run_to(16);
    chk("t3_done_cyc",  done_cyc,     13);
    chk("t3_n_done",    n_done,       1);
    chk("t3_out_addr",  bus.out_addr, 1);

    // 4: two filters per window
    begin_test("t4", 3, 2, 1'b0);
    run_to(9);
    chk("t4_wfen_first", bus.wfen, 1);
    chk("t4_dsen_first", n_dsen,   0);
    run_to(17);
    chk("t4_n_wfen",    n_wfen,       1);
    chk("t4_n_dsen",    n_dsen,       1);
    chk("t4_n_done",    n_done,       2);
    chk("t4_done_cyc",  done_cyc,     16);
    chk("t4_out_addr",  bus.out_addr, 2);

    // 5: end of row, row slot switch, then a second row
    begin_test("t5", 3, 1, 1'b1);
    rr1 = 11;
    run_to(9);
    chk("t5_num_next",   bus.num, 0);
    run_to(10);
    chk("t5_num_rowsw",  bus.num, 1);
    chk("t5_ldds",       bus.ldds, 1);
    chk("t5_sel_next",   bus.sel_next, 1);
    run_to(11);
    chk("t5_idle_busy",  bus.busy, 0);
    run_to(21);
    chk("t5_num_row2",   bus.num, 0);
    run_to(22);
    chk("t5_n_rowsw",    n_rowsw, 2);
    chk("t5_out_addr",   bus.out_addr, 2);
    chk("t5_n_dsen",     n_dsen, 0);

    // 6: 16 single-element psums, out_addr wraps 15 -> 0
    begin_test("t6", 1, 1, 1'b0);
    run_to(61);
    chk("t6_n_done_15",  n_done,       15);
    chk("t6_out_addr15", bus.out_addr, 15);
    run_to(65);
    chk("t6_n_done_16",  n_done,       16);
    chk("t6_done_cyc",   done_cyc,     64);
    chk("t6_out_wrap",   bus.out_addr, 0);

    // 7: reset asserted during ACC of the second row's psum
    begin_test("t7", 1, 1, 1'b1);
    rr1 = 7;
    rst_at = 10;
    run_to(9);
    chk("t7_pre_num",      bus.num,      1);
    chk("t7_pre_out_addr", bus.out_addr, 1);
    chk("t7_pre_acc",      bus.busy,     1);
    run_to(11);
    chk("t7_busy",     bus.busy,     0);
    chk("t7_num",      bus.num,      0);
    chk("t7_out_addr", bus.out_addr, 0);
    run_to(14);
    chk("t7_n_done",   n_done,       1);
    chk("t7_idle",     bus.busy,     0);

    chk("overlap_strobes", n_overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
